// File: rtl/iob_iob2axi_read_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// iob_iob2axi_read_ctrl_pkg
//   Shared definitions for the iob2axi transfer controllers (read and write
//   sides): controller state encoding, default geometry, the 4 KB burst
//   boundary, and helpers deriving bytes-per-beat and maximum burst length.
// ----------------------------------------------------------------------------
package iob_iob2axi_read_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } ctrl_state_t;

    localparam int IOB2AXI_ADDR_W    = 32;
    localparam int IOB2AXI_DATA_W    = 32;
    localparam int IOB2AXI_AXI_LEN_W = 8;
    localparam int IOB2AXI_LEN_W     = 16;

    // AXI bursts must not cross a 4 KB address boundary.
    localparam int IOB2AXI_BOUND_W     = 12;
    localparam int IOB2AXI_BOUND_BYTES = 2 ** IOB2AXI_BOUND_W;

    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int max_beats(input int axi_len_w);
        return 2 ** axi_len_w;
    endfunction

    localparam int BPB       = bytes_per_beat(IOB2AXI_DATA_W);
    localparam int MAX_BEATS = max_beats(IOB2AXI_AXI_LEN_W);

endpackage

// File: rtl/iob_iob2axi_burst_calc.sv
// ----------------------------------------------------------------------------
// iob_iob2axi_burst_calc
//   Combinational burst sizer: beats = min(rem, MAX_BEATS, words to the next
//   boundary). Shared by the read and write controllers.
//   Ports:
//     addr_i   in   BOUND_W       low address bits (beat aligned)
//     rem_i    in   LEN_W         beats still to transfer
//     beats_o  out  AXI_LEN_W+1   beats of the next burst
//   Assumes LEN_W >= AXI_LEN_W+1 and BOUND_W < 31.
// ----------------------------------------------------------------------------
module iob_iob2axi_burst_calc
    import iob_iob2axi_read_ctrl_pkg::*;
#(
    parameter int DATA_W    = IOB2AXI_DATA_W,
    parameter int AXI_LEN_W = IOB2AXI_AXI_LEN_W,
    parameter int LEN_W     = IOB2AXI_LEN_W,
    parameter int BOUND_W   = IOB2AXI_BOUND_W
) (
    input  logic [BOUND_W-1:0]   addr_i,
    input  logic [LEN_W-1:0]     rem_i,
    output logic [AXI_LEN_W:0]   beats_o
);

    localparam int BEAT_BYTES = bytes_per_beat(DATA_W);
    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int BW         = AXI_LEN_W + 1;

    localparam logic [BOUND_W:0] BOUND_SIZE = {1'b1, {BOUND_W{1'b0}}};
    localparam logic [BW-1:0]    BURST_MAX  = {1'b1, {AXI_LEN_W{1'b0}}};

    logic [BOUND_W:0] bytes_left;
    logic [BOUND_W:0] words_left;
    logic [BW-1:0]    cap;

    // NOTE: combinational logic uses blocking assignments and assigns every
    // output on every path, so no latch can be inferred.
    always_comb begin
        bytes_left = BOUND_SIZE - {1'b0, addr_i};
        words_left = bytes_left >> OFF_W;
        // Saturate: a whole boundary window may hold more beats than one burst.
        if (32'(words_left) >= 32'(BURST_MAX)) begin
            cap = BURST_MAX;
        end else begin
            cap = BW'(words_left);
        end
        if (32'(rem_i) < 32'(cap)) begin
            beats_o = BW'(rem_i);
        end else begin
            beats_o = cap;
        end
    end

endmodule

// File: rtl/iob_iob2axi_read_ctrl.sv
// ----------------------------------------------------------------------------
// iob_iob2axi_read_ctrl
//   Transfer sequencer for the iob2axi read burst engine. Splits one request
//   (base address, word count) into AXI INCR bursts of at most MAX_BEATS beats
//   that never cross a 4 KB boundary, issues them one at a time over the
//   engine run/ready handshake, and ORs the per-burst errors into one status.
//   Ports:
//     clk_i, rst_i      clock, asynchronous active-high reset
//     start_i           transfer request, sampled in IDLE only
//     addr_i            base byte address (low beat-offset bits ignored)
//     nwords_i          beats to read, 0 completes immediately
//     busy_o            transfer in progress
//     done_o            one-cycle pulse at transfer end
//     error_o           OR of burst errors of the last transfer
//     eng_run_o         engine run request
//     eng_addr_o        burst start address
//     eng_length_o      burst beats minus 1
//     eng_ready_i       engine idle flag
//     eng_error_i       error of the engine's last completed burst
// ----------------------------------------------------------------------------
module iob_iob2axi_read_ctrl
    import iob_iob2axi_read_ctrl_pkg::*;
#(
    parameter int ADDR_W    = IOB2AXI_ADDR_W,
    parameter int DATA_W    = IOB2AXI_DATA_W,
    parameter int AXI_LEN_W = IOB2AXI_AXI_LEN_W,
    parameter int LEN_W     = IOB2AXI_LEN_W,
    parameter int BOUND_W   = IOB2AXI_BOUND_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [LEN_W-1:0]     nwords_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 eng_run_o,
    output logic [ADDR_W-1:0]    eng_addr_o,
    output logic [AXI_LEN_W-1:0] eng_length_o,
    input  logic                 eng_ready_i,
    input  logic                 eng_error_i
);

    localparam int BEAT_BYTES = bytes_per_beat(DATA_W);
    localparam int OFF_W      = $clog2(BEAT_BYTES);
    localparam int BW         = AXI_LEN_W + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BEAT_BYTES - 1);

    ctrl_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [BW-1:0]        beats_q, beats_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [ADDR_W-1:0]    eng_addr_q, eng_addr_d;
    logic [AXI_LEN_W-1:0] eng_len_q, eng_len_d;
    logic                 run_q;
    logic [BW-1:0]        beats_calc;

    iob_iob2axi_burst_calc #(
        .DATA_W    (DATA_W),
        .AXI_LEN_W (AXI_LEN_W),
        .LEN_W     (LEN_W),
        .BOUND_W   (BOUND_W)
    ) u_burst_calc (
        .addr_i  (addr_q[BOUND_W-1:0]),
        .rem_i   (rem_q),
        .beats_o (beats_calc)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        eng_addr_d = eng_addr_q;
        eng_len_d  = eng_len_q;
        eng_run_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    error_d = 1'b0;
                    if (nwords_i != '0) begin
                        addr_d  = addr_i & ALIGN_MASK;
                        rem_d   = nwords_i;
                        busy_d  = 1'b1;
                        state_d = ST_CALC;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                beats_d    = beats_calc;
                eng_addr_d = addr_q;
                eng_len_d  = AXI_LEN_W'(beats_calc - BW'(1));
                state_d    = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Run only while the engine is idle: it reloads its address
                // register on every run cycle. Ready falling after a cycle of
                // run means the burst has been taken.
                eng_run_o = eng_ready_i;
                if (run_q && !eng_ready_i) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (eng_ready_i) begin
                    error_d = error_q | eng_error_i;
                    addr_d  = addr_q + (ADDR_W'(beats_q) << OFF_W);
                    rem_d   = rem_q - LEN_W'(beats_q);
                    if (rem_d == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, and every
    // register (no memories here) is cleared by the asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beats_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            eng_addr_q <= '0;
            eng_len_q  <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            eng_addr_q <= eng_addr_d;
            eng_len_q  <= eng_len_d;
            run_q      <= eng_run_o;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign eng_addr_o   = eng_addr_q;
    assign eng_length_o = eng_len_q;

endmodule
